// File: rtl/alu_cmd_driver.sv
// Command front end for the handshake ALU: buffers client requests in a FIFO,
// issues them one at a time and returns each result or error in command order.
module alu_cmd_driver #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_mode,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             alu_valid,
    output logic [3:0]       alu_mode,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic             alu_ready,
    input  logic [63:0]      alu_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             busy
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       MODE_MAX = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic [3:0]       mode;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    state_t           r_state;
    state_t           w_state_nxt;
    cmd_t             r_fifo [DEPTH];
    logic [ADDR_W:0]  r_wr_ptr;
    logic [ADDR_W:0]  r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_illegal;
    logic [3:0]       r_alu_mode;
    logic [31:0]      r_alu_a;
    logic [31:0]      r_alu_b;
    logic [63:0]      r_res_data;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_err;

    cmd_t w_cmd_in;
    cmd_t w_head;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_cmd_in = {cmd_mode, cmd_a, cmd_b, cmd_tag};
    assign w_head   = r_fifo[r_rd_ptr[ADDR_W-1:0]];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                      (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_push   = cmd_valid && !w_full;
    assign w_pop    = (r_state == S_IDLE) && !w_empty;

    // NOTE: storage array has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr[ADDR_W-1:0]] <= w_cmd_in;
    end

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: default assigned first so no path through the case leaves the
    // next state unassigned (which would infer a latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_nxt = S_ISSUE;
            // An illegal mode still spends one cycle here, with the strobe
            // suppressed, so its error response lines up one cycle later.
            S_ISSUE: w_state_nxt = r_illegal ? S_RESP : S_WAIT;
            S_WAIT:  if (alu_ready || (r_cnt == CNT_LAST)) w_state_nxt = S_RESP;
            S_RESP:  if (res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_illegal  <= 1'b0;
            r_alu_mode <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_res_data <= '0;
            r_res_tag  <= '0;
            r_res_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_pop) begin
                    r_res_tag <= w_head.tag;
                    r_illegal <= (w_head.mode > MODE_MAX);
                    if (w_head.mode <= MODE_MAX) begin
                        r_alu_mode <= w_head.mode;
                        r_alu_a    <= w_head.a;
                        r_alu_b    <= w_head.b;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                    if (r_illegal) begin
                        r_res_data <= '0;
                        r_res_err  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // A result arriving on the final count still wins over timeout.
                    if (alu_ready) begin
                        r_res_data <= alu_data;
                        r_res_err  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_res_data <= '0;
                        r_res_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = !w_full;
    assign alu_valid = (r_state == S_ISSUE) && !r_illegal;
    assign alu_mode  = r_alu_mode;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign res_valid = (r_state == S_RESP);
    assign res_data  = r_res_data;
    assign res_tag   = r_res_tag;
    assign res_err   = r_res_err;
    assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule
